// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block that sits beside dmemory32.
// Decodes the top 1 KiB of address space and maps the LED register, the
// debounced switches, a status register (bit0 = switch-change flag) and,
// optionally, a 7-segment display register.
// Optional feature macro: SEG7_EN (adds the SEG register, the digit scanner
// and the seg_an/seg_cat ports).
module mmio_io_ctrl #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int SW_W            = 24,
   parameter int LED_W           = 24
`ifdef SEG7_EN
   ,
   parameter int SCAN_DIV        = 1000
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       mem_addr,
   input  logic              mem_wen,
   input  logic              mem_ren,
   input  logic [31:0]       mem_wdata,
   output logic              io_sel,
   output logic [31:0]       io_rdata,
   input  logic [SW_W-1:0]   switch_i,
   output logic [LED_W-1:0]  led_o,
   output logic              sw_irq
`ifdef SEG7_EN
   ,
   output logic [7:0]        seg_an,
   output logic [7:0]        seg_cat
`endif
);

   // Word indices (mem_addr[9:2]) of the mapped registers.
   localparam logic [7:0] OFF_LED    = 8'h18;  // 0xFFFFFC60
   localparam logic [7:0] OFF_SWITCH = 8'h1C;  // 0xFFFFFC70
   localparam logic [7:0] OFF_STATUS = 8'h1D;  // 0xFFFFFC74
`ifdef SEG7_EN
   localparam logic [7:0] OFF_SEG    = 8'h20;  // 0xFFFFFC80
`endif

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   // The window closes on the edge where cnt would step to DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [7:0]        word_idx;
   logic              wr_en;
   logic              rd_en;
   logic [31:0]       rd_word;

   logic [LED_W-1:0]  led_reg, led_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              chg_reg, chg_next;

   logic [SW_W-1:0]   sync1_reg, sync2_reg, sync_prev_reg;
   logic [SW_W-1:0]   stable_reg, stable_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              sw_update;

   // Address bits [1:0] are ignored: registers are decoded per word.
   logic unused_bits;
   assign unused_bits = ^mem_addr[1:0];

   assign io_sel   = (mem_addr[31:10] == 22'h3FFFFF);
   assign word_idx = mem_addr[9:2];
   assign wr_en    = io_sel & mem_wen;
   assign rd_en    = io_sel & mem_ren;

   assign led_o    = led_reg;
   assign io_rdata = rdata_reg;
   assign sw_irq   = chg_reg;

`ifdef SEG7_EN
   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   logic [31:0]       seg_reg, seg_next;
   logic [SCAN_W-1:0] scan_cnt_reg;
   logic [2:0]        digit_reg;
   logic [7:0]        an_next;
   logic [3:0]        nibble;
   logic [7:0]        seg_an_reg, seg_cat_reg;

   // Active-low a..g pattern, bit0 = a, bit6 = g.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_an
         assign an_next[gi] = (digit_reg != 3'(gi));
      end
   endgenerate

   assign nibble  = seg_reg[{digit_reg, 2'b00} +: 4];
   assign seg_an  = seg_an_reg;
   assign seg_cat = seg_cat_reg;

   // SEG register write.
   always_comb begin
      seg_next = seg_reg;
      if (wr_en && word_idx == OFF_SEG)
         seg_next = mem_wdata;
   end

   // Digit scanner: one digit per SCAN_DIV clocks, registered drive, dp off.
   always_ff @(posedge clock) begin
      if (reset) begin
         seg_reg      <= '0;
         scan_cnt_reg <= '0;
         digit_reg    <= '0;
         seg_an_reg   <= 8'hFF;
         seg_cat_reg  <= 8'hFF;
      end else begin
         seg_reg <= seg_next;
         if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 3'd1;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end
         seg_an_reg  <= an_next;
         seg_cat_reg <= {1'b1, hex7(nibble)};
      end
   end
`endif

   // Load data mux; unmapped words and unused upper bits read as 0.
   always_comb begin
      rd_word = '0;
      case (word_idx)
         OFF_LED:    rd_word = 32'(led_reg);
         OFF_SWITCH: rd_word = 32'(stable_reg);
         OFF_STATUS: rd_word = {31'b0, chg_reg};
`ifdef SEG7_EN
         OFF_SEG:    rd_word = seg_reg;
`endif
         default:    rd_word = '0;
      endcase
   end

   // Debounce: a synced value must hold unchanged for a full window.
   always_comb begin
      cnt_next    = cnt_reg;
      stable_next = stable_reg;
      sw_update   = 1'b0;
      if (sync2_reg == stable_reg || sync2_reg != sync_prev_reg) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
         stable_next = sync2_reg;
         cnt_next    = '0;
         sw_update   = 1'b1;
      end else if (cnt_reg != {CNT_W{1'b1}}) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // Bus side next-state: stores, loads and the change flag.
   always_comb begin
      led_next   = led_reg;
      rdata_next = rdata_reg;
      chg_next   = chg_reg;
      if (wr_en && word_idx == OFF_LED)
         led_next = mem_wdata[LED_W-1:0];
      if (rd_en)
         rdata_next = rd_word;
      // A completing debounce wins over a same-cycle STATUS load.
      if (sw_update)
         chg_next = 1'b1;
      else if (rd_en && word_idx == OFF_STATUS)
         chg_next = 1'b0;
   end

   // State registers; reset also discards any debounce in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         led_reg       <= '0;
         rdata_reg     <= '0;
         chg_reg       <= 1'b0;
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         sync_prev_reg <= '0;
         stable_reg    <= '0;
         cnt_reg       <= '0;
      end else begin
         led_reg       <= led_next;
         rdata_reg     <= rdata_next;
         chg_reg       <= chg_next;
         sync1_reg     <= switch_i;
         sync2_reg     <= sync1_reg;
         sync_prev_reg <= sync2_reg;
         stable_reg    <= stable_next;
         cnt_reg       <= cnt_next;
      end
   end

endmodule
